fetch_unit: RTL and testbench

//   Instruction fetch stage with a prefetch queue, upstream of the decode stage register pair.

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : instruction fetch stage with a prefetch queue feeding decode
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                            CLK,
  input  logic                            RESET,
  output logic [ADDR_WIDTH-1:0]           INSTRUCTION_ADDR,
  input  logic [31:0]                     INSTRUCTION,
  input  logic                            STALL,
  input  logic                            REDIRECT,
  input  logic [ADDR_WIDTH-1:0]           REDIRECT_PC,
  output logic [ADDR_WIDTH-1:0]           PC_DECODE,
  output logic [31:0]                     INSTRUCTION_DECODE,
  output logic                            DECODE_VALID,
  output logic [$clog2(FIFO_DEPTH):0]     FIFO_COUNT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] q_pc    [FIFO_DEPTH];
  logic [31:0]           q_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic [CNT_W-1:0]      occupancy;
  logic                  can_issue;
  logic                  push;
  logic                  pop;

  // An outstanding ROM read reserves a queue slot, so the queue never overflows.
  assign occupancy = count + CNT_W'(inflight);
  assign can_issue = !REDIRECT && (occupancy < CNT_W'(FIFO_DEPTH));
  assign push      = inflight;
  assign pop       = !STALL && (count != '0);

  assign INSTRUCTION_ADDR = pc;
  assign FIFO_COUNT       = count;

  always_ff @(posedge CLK) begin
    if (push) begin
      q_pc[wr_ptr]    <= inflight_pc;
      q_instr[wr_ptr] <= INSTRUCTION;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc                 <= '0;
      inflight           <= 1'b0;
      inflight_pc        <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      PC_DECODE          <= '0;
      INSTRUCTION_DECODE <= NOP_INSTR;
      DECODE_VALID       <= 1'b0;
    end else if (REDIRECT) begin
      // Clearing inflight drops the word returning for the pre-redirect fetch.
      pc                 <= REDIRECT_PC;
      inflight           <= 1'b0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      INSTRUCTION_DECODE <= NOP_INSTR;
      DECODE_VALID       <= 1'b0;
    end else begin
      if (can_issue) begin
        inflight    <= 1'b1;
        inflight_pc <= pc;
        pc          <= pc + 1'b1;
      end else begin
        inflight <= 1'b0;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr             <= rd_ptr + 1'b1;
        PC_DECODE          <= q_pc[rd_ptr];
        INSTRUCTION_DECODE <= q_instr[rd_ptr];
        DECODE_VALID       <= 1'b1;
      end else if (!STALL) begin
        INSTRUCTION_DECODE <= NOP_INSTR;
        DECODE_VALID       <= 1'b0;
      end

      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit (ROM[i] = i)
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam int          AW  = 10;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] instruction_addr;
  logic [31:0]   instruction = 32'h0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] pc_decode;
  logic [31:0]   instruction_decode;
  logic          decode_valid;
  logic [2:0]    fifo_count;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4), .NOP_INSTR(NOP)) dut (
    .CLK                (clk),
    .RESET              (reset),
    .INSTRUCTION_ADDR   (instruction_addr),
    .INSTRUCTION        (instruction),
    .STALL              (stall),
    .REDIRECT           (redirect),
    .REDIRECT_PC        (redirect_pc),
    .PC_DECODE          (pc_decode),
    .INSTRUCTION_DECODE (instruction_decode),
    .DECODE_VALID       (decode_valid),
    .FIFO_COUNT         (fifo_count)
  );

  always #5 clk = ~clk;

  // Synchronous ROM holding ROM[i] = i.
  always @(posedge clk) instruction <= {22'b0, instruction_addr};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 10'h55;
    step();
    checks++; if (instruction_addr !== 10'h0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", instruction_addr); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (pc_decode !== 10'h0) begin errors++; $display("FAIL reset_pc_decode: got %0h expected 0", pc_decode); end
    checks++; if (instruction_decode !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", instruction_decode, NOP); end
    checks++; if (decode_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", decode_valid); end
  endtask

  // Free-run from reset: first valid at edge 3, then PC_DECODE 1..5.
  task automatic test_startup();
    reset = 1'b0; stall = 1'b0; redirect = 1'b0;
    step();
    checks++; if (decode_valid !== 1'b0 || instruction_addr !== 10'd1) begin errors++; $display("FAIL start_e1: valid=%b addr=%0h expected valid=0 addr=1", decode_valid, instruction_addr); end
    step();
    checks++; if (decode_valid !== 1'b0 || fifo_count !== 3'd1) begin errors++; $display("FAIL start_e2: valid=%b count=%0d expected valid=0 count=1", decode_valid, fifo_count); end
    step();
    checks++; if (decode_valid !== 1'b1 || pc_decode !== 10'd0 || instruction_decode !== 32'd0) begin errors++; $display("FAIL start_e3: valid=%b pc=%0h instr=%0h expected 1/0/0", decode_valid, pc_decode, instruction_decode); end
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (decode_valid !== 1'b1 || pc_decode !== AW'(k) || instruction_decode !== 32'(k)) begin errors++; $display("FAIL stream_%0d: valid=%b pc=%0h instr=%0h expected pc=instr=%0h", k, decode_valid, pc_decode, instruction_decode, k); end
    end
  endtask

  // Stall 10 cycles holding PC_DECODE=5; queue fills, fetch freezes at 10.
  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (decode_valid !== 1'b1 || pc_decode !== 10'd5) begin errors++; $display("FAIL stall_hold_%0d: valid=%b pc=%0h expected 1/5", k, decode_valid, pc_decode); end
    end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL stall_full: got %0d expected 4", fifo_count); end
    checks++; if (instruction_addr !== 10'd10) begin errors++; $display("FAIL stall_addr: got %0h expected a", instruction_addr); end
    stall = 1'b0;
    for (int k = 6; k <= 11; k++) begin
      step();
      checks++; if (decode_valid !== 1'b1 || pc_decode !== AW'(k) || instruction_decode !== 32'(k)) begin errors++; $display("FAIL drain_%0d: valid=%b pc=%0h instr=%0h expected %0h", k, decode_valid, pc_decode, instruction_decode, k); end
    end
  endtask

  // One stall edge brings the queue to 3, then redirect to 0x40.
  task automatic test_redirect();
    stall = 1'b1;
    step();
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL redir_pre_count: got %0d expected 3", fifo_count); end
    stall = 1'b0; redirect = 1'b1; redirect_pc = 10'h40;
    step();
    redirect = 1'b0;
    checks++; if (decode_valid !== 1'b0 || fifo_count !== 3'd0 || instruction_decode !== NOP) begin errors++; $display("FAIL redir_flush: valid=%b count=%0d instr=%h expected 0/0/nop", decode_valid, fifo_count, instruction_decode); end
    checks++; if (instruction_addr !== 10'h40) begin errors++; $display("FAIL redir_addr: got %0h expected 40", instruction_addr); end
    step();
    checks++; if (decode_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL redir_drop: valid=%b count=%0d expected 0/0", decode_valid, fifo_count); end
    step();
    checks++; if (decode_valid !== 1'b0 || fifo_count !== 3'd1) begin errors++; $display("FAIL redir_e2: valid=%b count=%0d expected 0/1", decode_valid, fifo_count); end
    step();
    checks++; if (decode_valid !== 1'b1 || pc_decode !== 10'h40 || instruction_decode !== 32'h40) begin errors++; $display("FAIL redir_target: valid=%b pc=%0h instr=%0h expected 1/40/40", decode_valid, pc_decode, instruction_decode); end
    step();
    checks++; if (decode_valid !== 1'b1 || pc_decode !== 10'h41) begin errors++; $display("FAIL redir_next: valid=%b pc=%0h expected 1/41", decode_valid, pc_decode); end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 10'h80;
    step();
    redirect = 1'b0; stall = 1'b0;
    checks++; if (decode_valid !== 1'b0 || instruction_decode !== NOP || fifo_count !== 3'd0) begin errors++; $display("FAIL rstall_flush: valid=%b instr=%h count=%0d expected 0/nop/0", decode_valid, instruction_decode, fifo_count); end
    step(); step(); step();
    checks++; if (decode_valid !== 1'b1 || pc_decode !== 10'h80 || instruction_decode !== 32'h80) begin errors++; $display("FAIL rstall_target: valid=%b pc=%0h instr=%0h expected 1/80/80", decode_valid, pc_decode, instruction_decode); end
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1; redirect_pc = 10'h10;
    step();
    redirect_pc = 10'h20;
    step();
    redirect = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      checks++; if (decode_valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble_%0d: valid=%b pc=%0h expected valid 0", k, decode_valid, pc_decode); end
    end
    step();
    checks++; if (decode_valid !== 1'b1 || pc_decode !== 10'h20 || instruction_decode !== 32'h20) begin errors++; $display("FAIL b2b_target: valid=%b pc=%0h instr=%0h expected 1/20/20", decode_valid, pc_decode, instruction_decode); end
    step();
    checks++; if (decode_valid !== 1'b1 || pc_decode !== 10'h21) begin errors++; $display("FAIL b2b_next: valid=%b pc=%0h expected 1/21", decode_valid, pc_decode); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_pc [4];
    exp_pc[0] = 10'h3FE; exp_pc[1] = 10'h3FF; exp_pc[2] = 10'h000; exp_pc[3] = 10'h001;
    redirect = 1'b1; redirect_pc = 10'h3FE;
    step();
    redirect = 1'b0;
    step(); step();
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (decode_valid !== 1'b1 || pc_decode !== exp_pc[k] || instruction_decode !== {22'b0, exp_pc[k]}) begin errors++; $display("FAIL wrap_%0d: valid=%b pc=%0h instr=%0h expected %0h", k, decode_valid, pc_decode, instruction_decode, exp_pc[k]); end
    end
  endtask

  // Reset with a full queue, pending stall and redirect; startup timing repeats.
  task automatic test_mid_reset();
    stall = 1'b1;
    for (int k = 0; k < 6; k++) step();
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL mreset_full: got %0d expected 4", fifo_count); end
    test_reset();
    test_startup();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
